// File: rtl/rs232_rx_bit_sampler.sv
// RS232 receive front end: synchronises rx_i, finds the start bit, and strobes out
// eight mid-bit data samples per frame before checking the stop bit.
module rs232_rx_bit_sampler #(
  parameter int unsigned CLK_DIV = 434,
  parameter int unsigned CNT_W   = 16
) (
  input  logic clk_ref,
  input  logic rst,
  input  logic rx_i,
  output logic clk_rcpt,
  output logic r_di,
  output logic busy,
  output logic frame_err
);

  localparam logic [CNT_W-1:0] HalfLoad = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BitLoad  = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             strobe_q, strobe_d;
  logic             rdi_q, rdi_d;
  logic             ferr_q, ferr_d;
  logic             rx_m, rx_s, rx_s_d;

  // Synchroniser flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_m   <= rx_i;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
    end
  end

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      strobe_q <= 1'b0;
      rdi_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      rdi_q    <= rdi_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    strobe_d = 1'b0;
    rdi_d    = rdi_q;
    ferr_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s && rx_s_d) begin
          cnt_d   = HalfLoad;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          // Line back high at mid start bit: treat as a glitch.
          if (!rx_s) begin
            cnt_d   = BitLoad;
            idx_d   = 3'd0;
            state_d = StData;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          rdi_d    = rx_s;
          strobe_d = 1'b1;
          idx_d    = idx_q + 3'd1;
          cnt_d    = BitLoad;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StBreak: begin
        // Hold off until the line returns high so a break is not a new start.
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign clk_rcpt  = strobe_q;
  assign r_di      = rdi_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_rs232_rx_bit_sampler.sv
// Scoreboard bench for rs232_rx_bit_sampler: one instance at CLK_DIV=16, one at CLK_DIV=5.
module tb_rs232_rx_bit_sampler;

  typedef struct {
    logic b;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx16 = 1'b1;
  logic rx5 = 1'b1;
  logic strb16, rdi16, busy16, ferr16;
  logic strb5, rdi5, busy5, ferr5;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  exp_t q16[$];
  exp_t q5[$];
  int   fq16[$];
  int   fq5[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rs232_rx_bit_sampler #(.CLK_DIV(16), .CNT_W(16)) dut16 (
    .clk_ref(clk), .rst(rst), .rx_i(rx16),
    .clk_rcpt(strb16), .r_di(rdi16), .busy(busy16), .frame_err(ferr16)
  );

  rs232_rx_bit_sampler #(.CLK_DIV(5), .CNT_W(8)) dut5 (
    .clk_ref(clk), .rst(rst), .rx_i(rx5),
    .clk_rcpt(strb5), .r_di(rdi5), .busy(busy5), .frame_err(ferr5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Strobe / frame_err monitors pop the scoreboard on every DUT event.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && strb16) begin
      if (q16.size() == 0) check("spurious_strobe16", 1, 0);
      else begin
        e = q16.pop_front();
        check("bit16", {31'd0, rdi16}, {31'd0, e.b});
        check("strobe_cyc16", cyc, e.cyc);
      end
    end
    if (!rst && strb5) begin
      if (q5.size() == 0) check("spurious_strobe5", 1, 0);
      else begin
        e = q5.pop_front();
        check("bit5", {31'd0, rdi5}, {31'd0, e.b});
        check("strobe_cyc5", cyc, e.cyc);
      end
    end
    if (!rst && ferr16) begin
      if (fq16.size() == 0) check("spurious_ferr16", 1, 0);
      else check("ferr_cyc16", cyc, fq16.pop_front());
    end
    if (!rst && ferr5) begin
      if (fq5.size() == 0) check("spurious_ferr5", 1, 0);
      else check("ferr_cyc5", cyc, fq5.pop_front());
    end
  end

  // Called at a negedge. Edge is detected 3 posedges after rx falls; sample k follows
  // after CLK_DIV/2 + (k+1)*CLK_DIV more.
  task automatic send(input bit sel5, input logic [7:0] data, input logic stop);
    int d = sel5 ? 5 : 16;
    int base = cyc + 3 + d / 2;
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.b = data[k];
      e.cyc = base + d * (k + 1);
      if (sel5) q5.push_back(e);
      else q16.push_back(e);
    end
    if (!stop) begin
      if (sel5) fq5.push_back(base + 9 * d);
      else fq16.push_back(base + 9 * d);
    end
    if (sel5) rx5 = 1'b0;
    else rx16 = 1'b0;
    repeat (d) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      if (sel5) rx5 = data[k];
      else rx16 = data[k];
      repeat (d) @(negedge clk);
    end
    if (sel5) rx5 = stop;
    else rx16 = stop;
    repeat (d) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    repeat (40) @(negedge clk);
    check(tag, q16.size() + q5.size() + fq16.size() + fq5.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int nb;
    int base;
    logic [7:0] partial;
    exp_t e;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_outs16", {28'd0, strb16, rdi16, busy16, ferr16}, 0);
    check("reset_outs5", {28'd0, strb5, rdi5, busy5, ferr5}, 0);
    repeat (10) @(negedge clk);

    // 0xA5, good stop
    send(1'b0, 8'hA5, 1'b1);
    check("busy_after_stop_a5", {31'd0, busy16}, 0);
    drain("drain_a5");

    // 4-cycle low glitch
    nb = 0;
    rx16 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) rx16 = 1'b1;
      @(negedge clk);
      if (busy16) nb++;
    end
    check("glitch_busy_cycles", nb, 8);
    drain("drain_glitch");

    // 0x3C with a low stop, then a held break
    send(1'b0, 8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    check("break_busy_held", {31'd0, busy16}, 1);
    rx16 = 1'b1;
    repeat (6) @(negedge clk);
    check("break_released", {31'd0, busy16}, 0);
    drain("drain_3c");

    // back-to-back frames
    send(1'b0, 8'h00, 1'b1);
    send(1'b0, 8'hFF, 1'b1);
    drain("drain_b2b");

    // reset after the 3rd strobe of 0x81
    partial = 8'h81;
    base = cyc + 3 + 8;
    for (int k = 0; k < 3; k++) begin
      e.b = partial[k];
      e.cyc = base + 16 * (k + 1);
      q16.push_back(e);
    end
    rx16 = 1'b0;
    repeat (16) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rx16 = partial[k];
      repeat (16) @(negedge clk);
    end
    check("strobes_before_rst", q16.size(), 0);
    rx16 = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_outs16", {28'd0, strb16, rdi16, busy16, ferr16}, 0);
    repeat (200) @(negedge clk);
    send(1'b0, 8'h81, 1'b1);
    drain("drain_81");

    // odd divider
    send(1'b1, 8'h55, 1'b1);
    check("busy_after_stop_55", {31'd0, busy5}, 0);
    drain("drain_55");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
